// File: rtl/ex_stage.sv
// ex_stage: single-cycle execute stage with valid/allowin handshake, one-hot ALU and beq resolution
module ex_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_src1,
  input  logic [31:0] ds_src2,
  input  logic [31:0] ds_imm,
  input  logic [4:0]  ds_rd,
  input  logic [11:0] ds_alu_control,
  input  logic [5:0]  ds_ctrl,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_alu_result,
  output logic [31:0] es_store_data,
  output logic [4:0]  es_rd,
  output logic [3:0]  es_ms_ctrl,
  output logic        br_taken,
  output logic [31:0] br_target
);
  logic        es_valid;
  logic [31:0] es_src1, es_src2, es_imm;
  logic [11:0] es_alu_control;
  logic [5:0]  es_ctrl;
  logic [31:0] a, b, sra_r;
  logic        slt_r, sltu_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      es_valid       <= 1'b0;
      es_pc          <= PC_RESET;
      es_src1        <= '0;
      es_src2        <= '0;
      es_imm         <= '0;
      es_rd          <= '0;
      es_alu_control <= '0;
      es_ctrl        <= '0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid & ~br_taken;
      if (ds_to_es_valid) begin
        es_pc          <= ds_pc;
        es_src1        <= ds_src1;
        es_src2        <= ds_src2;
        es_imm         <= ds_imm;
        es_rd          <= ds_rd;
        es_alu_control <= ds_alu_control;
        es_ctrl        <= ds_ctrl;
      end
    end
  assign es_allowin     = ~es_valid | ms_allowin;
  assign es_to_ms_valid = es_valid;
  assign a              = es_src1;
  assign b              = es_ctrl[5] ? es_imm : es_src2;
  assign slt_r          = $signed(a) < $signed(b);
  assign sltu_r         = a < b;
  assign sra_r          = $signed(a) >>> b[4:0];
  // control is one-hot, so OR-ing masked per-op results selects the active op
  assign es_alu_result  = ({32{es_alu_control[0]}}  & (a + b))
                        | ({32{es_alu_control[1]}}  & (a - b))
                        | ({32{es_alu_control[2]}}  & {31'b0, slt_r})
                        | ({32{es_alu_control[3]}}  & {31'b0, sltu_r})
                        | ({32{es_alu_control[4]}}  & (a & b))
                        | ({32{es_alu_control[5]}}  & ~(a | b))
                        | ({32{es_alu_control[6]}}  & (a | b))
                        | ({32{es_alu_control[7]}}  & (a ^ b))
                        | ({32{es_alu_control[8]}}  & (a << b[4:0]))
                        | ({32{es_alu_control[9]}}  & (a >> b[4:0]))
                        | ({32{es_alu_control[10]}} & sra_r)
                        | ({32{es_alu_control[11]}} & b);
  assign es_store_data  = es_src2;
  assign es_ms_ctrl     = es_ctrl[3:0];
  assign br_taken       = es_valid & es_ctrl[4] & (es_alu_result == 32'h0);
  assign br_target      = es_pc + es_imm;
endmodule
